// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate engine: sequencer states, status
// codes, per-phase beat count, configuration limits and rotation codes.
package rot_pkg;

  localparam int unsigned DIM_W     = 16;
  localparam int unsigned DIM_SUM_W = DIM_W + 1;
  localparam int unsigned SETS_W    = 13;
  localparam int unsigned SET_CNT_W = 24;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned DEG_W     = 2;

  localparam int unsigned SET_BEATS = 64;
  localparam int unsigned BEAT_W    = $clog2(SET_BEATS);

  // Bits that must be clear in a legal height / width
  localparam logic [DIM_W-1:0] H_ILLEGAL_MASK = 16'h8000;
  localparam logic [DIM_W-1:0] W_ILLEGAL_MASK = 16'hC000;

  localparam logic [ERR_W-1:0] ERR_OK      = 3'd0;
  localparam logic [ERR_W-1:0] ERR_CFG     = 3'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd2;
  localparam logic [ERR_W-1:0] ERR_ABORT   = 3'd3;
  localparam logic [ERR_W-1:0] ERR_STOP    = 3'd4;

  localparam logic [DEG_W-1:0] DEG_0   = 2'd0;
  localparam logic [DEG_W-1:0] DEG_90  = 2'd1;
  localparam logic [DEG_W-1:0] DEG_180 = 2'd2;
  localparam logic [DEG_W-1:0] DEG_270 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_WAIT_GNT = 3'd2,
    ST_RUN_RD   = 3'd3,
    ST_RUN_WR   = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

endpackage

// File: rtl/rot_seq_ctrl_if.sv
// Control/status bundle between the register file side and the rotate job
// sequencer; master drives job requests, slave is the sequencer.
interface rot_seq_ctrl_if;
  import rot_pkg::*;

  logic                 I_RC_START;
  logic                 I_RC_ABORT;
  logic                 I_RC_IRQ_CLR;
  logic [DIM_W-1:0]     I_RC_HEIGHT;
  logic [DIM_W-1:0]     I_RC_WIDTH;
  logic [DEG_W-1:0]     I_RC_DEGREES;
  logic                 I_RC_DIRECTION;
  logic                 I_RC_DMA_GNT;
  logic                 I_RC_CS_STOP;

  logic                 O_RC_CS_RUN;
  logic [DIM_W-1:0]     O_RC_HEIGHT;
  logic [DIM_W-1:0]     O_RC_WIDTH;
  logic [DEG_W-1:0]     O_RC_DEGREES;
  logic                 O_RC_DIRECTION;
  logic                 O_RC_BUSY;
  logic                 O_RC_DONE_IRQ;
  logic [ERR_W-1:0]     O_RC_ERR;
  logic [SET_CNT_W-1:0] O_RC_SET_CNT;

  modport master (
    output I_RC_START, I_RC_ABORT, I_RC_IRQ_CLR, I_RC_HEIGHT, I_RC_WIDTH,
           I_RC_DEGREES, I_RC_DIRECTION, I_RC_DMA_GNT, I_RC_CS_STOP,
    input  O_RC_CS_RUN, O_RC_HEIGHT, O_RC_WIDTH, O_RC_DEGREES, O_RC_DIRECTION,
           O_RC_BUSY, O_RC_DONE_IRQ, O_RC_ERR, O_RC_SET_CNT
  );

  modport slave (
    input  I_RC_START, I_RC_ABORT, I_RC_IRQ_CLR, I_RC_HEIGHT, I_RC_WIDTH,
           I_RC_DEGREES, I_RC_DIRECTION, I_RC_DMA_GNT, I_RC_CS_STOP,
    output O_RC_CS_RUN, O_RC_HEIGHT, O_RC_WIDTH, O_RC_DEGREES, O_RC_DIRECTION,
           O_RC_BUSY, O_RC_DONE_IRQ, O_RC_ERR, O_RC_SET_CNT
  );

endinterface

// File: rtl/rot_cfg_chk.sv
// Registered image-config check: legality flag and expected 8x8 set count,
// captured on the accepted start so both are ready during CHECK.
module rot_cfg_chk
  import rot_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIM_W-1:0]     height,
  input  logic [DIM_W-1:0]     width,
  output logic                 valid_q,
  output logic [SET_CNT_W-1:0] expected_q
);

  logic                 valid_d;
  logic [SET_CNT_W-1:0] expected_d;
  logic [SETS_W-1:0]    h_sets;
  logic [SETS_W-1:0]    w_sets;

  always_comb begin
    valid_d    = valid_q;
    expected_d = expected_q;
    // Round each dimension up to whole 8-pixel tiles
    h_sets = SETS_W'((DIM_SUM_W'(height) + DIM_SUM_W'(7)) >> 3);
    w_sets = SETS_W'((DIM_SUM_W'(width)  + DIM_SUM_W'(7)) >> 3);
    if (load) begin
      valid_d = (height != '0) && (width != '0) &&
                ((height & H_ILLEGAL_MASK) == '0) &&
                ((width  & W_ILLEGAL_MASK) == '0);
      expected_d = SET_CNT_W'(h_sets) * SET_CNT_W'(w_sets);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      expected_q <= '0;
    end else begin
      valid_q    <= valid_d;
      expected_q <= expected_d;
    end
  end

endmodule

// File: rtl/rot_seq_ctrl.sv
// Rotate job sequencer: validates the config, then runs one read and one write
// phase per DMA grant until all 8x8 sets are done, ending with IRQ and status.
module rot_seq_ctrl
  import rot_pkg::*;
#(
  parameter int unsigned GNT_TIMEOUT = 1023
) (
  input  logic          I_RC_HCLK,
  input  logic          I_RC_HRESET,
  rot_seq_ctrl_if.slave bus
);

  localparam int unsigned          TO_W      = $clog2(GNT_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(SET_BEATS - 1);
  localparam logic [TO_W-1:0]      TO_LIMIT  = TO_W'(GNT_TIMEOUT);

  state_e               state_q,     state_d;
  logic                 cs_run_q,    cs_run_d;
  logic [DIM_W-1:0]     height_q,    height_d;
  logic [DIM_W-1:0]     width_q,     width_d;
  logic [DEG_W-1:0]     degrees_q,   degrees_d;
  logic                 direction_q, direction_d;
  logic                 busy_q,      busy_d;
  logic                 irq_q,       irq_d;
  logic [ERR_W-1:0]     err_q,       err_d;
  logic [SET_CNT_W-1:0] set_cnt_q,   set_cnt_d;
  logic [BEAT_W-1:0]    beat_q,      beat_d;
  logic [TO_W-1:0]      to_cnt_q,    to_cnt_d;
  logic                 stop_seen_q, stop_seen_d;

  logic                 start_acc;
  logic                 cfg_valid;
  logic [SET_CNT_W-1:0] expected;
  logic [SET_CNT_W-1:0] set_cnt_inc;
  logic [TO_W-1:0]      to_cnt_inc;
  logic                 stop_seen_now;

  assign start_acc = (state_q == ST_IDLE) && bus.I_RC_START;

  rot_cfg_chk u_cfg_chk (
    .clk        (I_RC_HCLK),
    .rst        (I_RC_HRESET),
    .load       (start_acc),
    .height     (bus.I_RC_HEIGHT),
    .width      (bus.I_RC_WIDTH),
    .valid_q    (cfg_valid),
    .expected_q (expected)
  );

  always_comb begin
    state_d       = state_q;
    cs_run_d      = cs_run_q;
    height_d      = height_q;
    width_d       = width_q;
    degrees_d     = degrees_q;
    direction_d   = direction_q;
    busy_d        = busy_q;
    err_d         = err_q;
    set_cnt_d     = set_cnt_q;
    beat_d        = beat_q;
    to_cnt_d      = '0;
    stop_seen_d   = stop_seen_q;
    set_cnt_inc   = set_cnt_q + SET_CNT_W'(1);
    to_cnt_inc    = to_cnt_q + TO_W'(1);
    stop_seen_now = stop_seen_q | bus.I_RC_CS_STOP;

    case (state_q)
      ST_IDLE: begin
        if (bus.I_RC_START) begin
          height_d    = bus.I_RC_HEIGHT;
          width_d     = bus.I_RC_WIDTH;
          degrees_d   = bus.I_RC_DEGREES;
          direction_d = bus.I_RC_DIRECTION;
          err_d       = ERR_OK;
          set_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cfg_valid) begin
          err_d   = ERR_CFG;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        // Grant wins over a timeout landing in the same cycle
        if (bus.I_RC_DMA_GNT) begin
          cs_run_d = 1'b1;
          beat_d   = '0;
          state_d  = ST_RUN_RD;
        end else if (to_cnt_inc == TO_LIMIT) begin
          err_d    = ERR_TIMEOUT;
          state_d  = ST_FINISH;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      ST_RUN_RD: begin
        beat_d      = beat_q + BEAT_W'(1);
        stop_seen_d = 1'b0;
        if (beat_q == BEAT_LAST) begin
          state_d = ST_RUN_WR;
        end
      end
      ST_RUN_WR: begin
        beat_d      = beat_q + BEAT_W'(1);
        stop_seen_d = stop_seen_now;
        if (beat_q == BEAT_LAST) begin
          set_cnt_d = set_cnt_inc;
          cs_run_d  = 1'b0;
          // Generator's last-set flag must coincide exactly with our count
          if (set_cnt_inc == expected) begin
            if (!stop_seen_now) err_d = ERR_STOP;
            state_d = ST_FINISH;
          end else if (stop_seen_now) begin
            err_d   = ERR_STOP;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_WAIT_GNT;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.I_RC_ABORT && (state_q != ST_IDLE)) begin
      state_d   = ST_FINISH;
      err_d     = ERR_ABORT;
      cs_run_d  = 1'b0;
      busy_d    = 1'b1;
      set_cnt_d = set_cnt_q;
      to_cnt_d  = '0;
    end

    // Set beats clear when both land in one cycle
    irq_d = irq_q;
    if (bus.I_RC_IRQ_CLR)      irq_d = 1'b0;
    if (state_q == ST_FINISH)  irq_d = 1'b1;
  end

  always_ff @(posedge I_RC_HCLK or posedge I_RC_HRESET) begin
    if (I_RC_HRESET) begin
      state_q     <= ST_IDLE;
      cs_run_q    <= 1'b0;
      height_q    <= '0;
      width_q     <= '0;
      degrees_q   <= '0;
      direction_q <= 1'b0;
      busy_q      <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= '0;
      set_cnt_q   <= '0;
      beat_q      <= '0;
      to_cnt_q    <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_run_q    <= cs_run_d;
      height_q    <= height_d;
      width_q     <= width_d;
      degrees_q   <= degrees_d;
      direction_q <= direction_d;
      busy_q      <= busy_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
      set_cnt_q   <= set_cnt_d;
      beat_q      <= beat_d;
      to_cnt_q    <= to_cnt_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign bus.O_RC_CS_RUN    = cs_run_q;
  assign bus.O_RC_HEIGHT    = height_q;
  assign bus.O_RC_WIDTH     = width_q;
  assign bus.O_RC_DEGREES   = degrees_q;
  assign bus.O_RC_DIRECTION = direction_q;
  assign bus.O_RC_BUSY      = busy_q;
  assign bus.O_RC_DONE_IRQ  = irq_q;
  assign bus.O_RC_ERR       = err_q;
  assign bus.O_RC_SET_CNT   = set_cnt_q;

endmodule

// File: doc/rot_seq_ctrl.md
Name: rot_seq_ctrl

Overview:
- Job sequencer for the rotate engine. It sits between the register file, the address generator and the DMA.
- On a start pulse it latches and validates the image configuration, then computes the expected number of 8x8 pixel sets.
- For each set it waits for a DMA grant and holds the generator's run/ready line high for one read phase plus one write phase.
- It counts completed sets and ends the job with a sticky done interrupt and an error code.

Parameters:
- SET_BEATS, 64, beats per phase. A read phase and a write phase each last SET_BEATS cycles.
- GNT_TIMEOUT, 1023, maximum cycles spent waiting for I_RC_DMA_GNT before the job is aborted with a timeout error.

Ports:
- I_RC_HCLK  in  1  clock.
- I_RC_HRESET  in  1  reset, asynchronous, active-high.
- I_RC_START  in  1  single-cycle job start from the register file.
- I_RC_ABORT  in  1  software abort.
- I_RC_IRQ_CLR  in  1  clears O_RC_DONE_IRQ.
- I_RC_HEIGHT  in  16  source height in pixels.
- I_RC_WIDTH  in  16  source width in pixels.
- I_RC_DEGREES  in  2  rotation amount: 0/90/180/270.
- I_RC_DIRECTION  in  1  1 = clockwise.
- I_RC_DMA_GNT  in  1  DMA can accept one set (read and write phases).
- I_RC_CS_STOP  in  1  last-set flag from the address generator.
- O_RC_CS_RUN  out  1  drives the generator's DMA-ready input.
- O_RC_HEIGHT  out  16  latched height.
- O_RC_WIDTH  out  16  latched width.
- O_RC_DEGREES  out  2  latched rotation amount.
- O_RC_DIRECTION  out  1  latched direction.
- O_RC_BUSY  out  1  a job is in progress.
- O_RC_DONE_IRQ  out  1  sticky completion interrupt.
- O_RC_ERR  out  3  status code: 0 ok, 1 invalid config, 2 grant timeout, 3 abort, 4 stop/count mismatch.
- O_RC_SET_CNT  out  24  number of completed sets.

Behaviour:
- Reset: every output is 0; the FSM goes to IDLE; all counters are 0. Reset asserted mid-job terminates the job immediately with no IRQ.
- States: IDLE, CHECK, WAIT_GNT, RUN_RD, RUN_WR, FINISH.
- IDLE:
  - I_RC_START latches the config outputs, clears O_RC_ERR and O_RC_SET_CNT, and moves to CHECK.
  - O_RC_BUSY rises on the cycle after START.
  - START while busy is ignored.
- CHECK (1 cycle):
  - The config is invalid if H==0, W==0, H[15]==1 or W[15:14]!=0. Invalid config sets ERR=1 and goes to FINISH.
  - Otherwise it registers expected = ((H+7)>>3)*((W+7)>>3). Each factor is 13 bits and the product is truncated to 24 bits; the maximum legal value is 4096*2048 = 2^23.
  - Then goes to WAIT_GNT.
- WAIT_GNT:
  - The timeout counter increments every cycle and is cleared on leaving the state.
  - GNT moves to RUN_RD, and O_RC_CS_RUN is 1 from the next cycle.
  - If the counter reaches GNT_TIMEOUT with no GNT: ERR=2, go to FINISH.
  - GNT and timeout in the same cycle: GNT wins.
- RUN_RD / RUN_WR:
  - A 6-bit beat counter counts 0..SET_BEATS-1 in each state, and O_RC_CS_RUN=1 throughout.
  - RUN is continuous for 2*SET_BEATS cycles with no gaps.
  - Beat 63 of RUN_RD moves to RUN_WR.
- End of RUN_WR (beat 63):
  - SET_CNT increments.
  - If SET_CNT+1 == expected: check that I_RC_CS_STOP was seen during this RUN_WR (flag captured while in RUN_WR). If it was not seen, ERR=4. Either way go to FINISH.
  - Else, if STOP was seen during RUN_WR: ERR=4, go to FINISH.
  - Else go back to WAIT_GNT.
  - O_RC_CS_RUN drops in the cycle after beat 63.
- I_RC_ABORT:
  - In any non-IDLE state, RUN drops next cycle, ERR=3 and the FSM goes to FINISH.
  - Abort has priority over every other transition.
  - Abort in IDLE is ignored.
- FINISH (1 cycle): set O_RC_DONE_IRQ, clear O_RC_BUSY next cycle, return to IDLE.
- IRQ:
  - O_RC_DONE_IRQ is cleared by I_RC_IRQ_CLR.
  - If a set and a clear happen in the same cycle, the set wins.
  - The IRQ stays asserted across a new START until cleared.
- Config outputs hold their values until the next accepted START. ERR and SET_CNT also hold after the job ends.

Decomposition:
- Package rot_pkg holds:
  - state encodings (3-bit);
  - ERR_* codes;
  - SET_BEATS;
  - the H/W legal-limit masks;
  - DEG_0/90/180/270 codes, shared with the address generator.
- Sub-module rot_cfg_chk: registered validity check plus the 13x13 multiply for the expected set count. One-cycle latency, consumed in CHECK.

Test Plan:
- H=16, W=16, deg=1, dir=1; GNT tied high; STOP pulsed in the final RUN_WR -> 4 sets, RUN high 128 cycles per set, SET_CNT=4, ERR=0, IRQ=1.
- H=9, W=20 -> expected=2*3=6 sets. With STOP withheld -> ERR=4 after set 6, IRQ=1.
- H=0x8000, W=8 -> ERR=1 in two cycles, RUN never asserted, IRQ=1.
- GNT held low with GNT_TIMEOUT=1023 -> ERR=2 after 1023 WAIT_GNT cycles, SET_CNT=0.
- ABORT at beat 30 of RUN_RD of set 2 -> RUN=0 next cycle, ERR=3, SET_CNT=1. A START during the job is ignored.
- Reset asserted mid RUN_WR -> all outputs 0 asynchronously. IRQ_CLR coincident with FINISH -> IRQ=1.
